// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin scheduler sharing one binary-to-BCD converter
// Optional feature macro: BCD_SCHED_CHANGE_DETECT_EN (auto re-convert on operand change)

module bcd_conv_sched #(
   parameter int NREQ     = 3,
   parameter int CONV_LAT = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [6*NREQ-1:0] bin_in,
   output logic              conv_gen,
   output logic [5:0]        conv_bin,
   input  logic [7:0]        conv_bcd,
   output logic [8*NREQ-1:0] bcd_q,
   output logic [NREQ-1:0]   done,
   output logic              busy
);
   localparam int GW = $clog2(NREQ);
   localparam int WW = $clog2(CONV_LAT + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          state;
   logic [NREQ-1:0] pending;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   g;
   logic [WW-1:0]   wcnt;

   logic            found;
   logic [GW-1:0]   grant_idx;
   logic [NREQ-1:0] grant_oh;
   logic [NREQ-1:0] set_mask;
   logic [GW-1:0]   ptr_next;

   // First pending requester at or after ptr, wrapping modulo NREQ
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && pending[(int'(ptr) + k) % NREQ]) begin
            found     = 1'b1;
            grant_idx = GW'((int'(ptr) + k) % NREQ);
            grant_oh[(int'(ptr) + k) % NREQ] = 1'b1;
         end
      end
   end

   assign ptr_next = (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + GW'(1);

`ifdef BCD_SCHED_CHANGE_DETECT_EN
   logic [6*NREQ-1:0] last_bin;

   // An operand that drifted from its last converted value requests itself
   always_comb begin
      set_mask = req;
      for (int i = 0; i < NREQ; i++) begin
         if ((bin_in[6*i +: 6] != last_bin[6*i +: 6]) && !pending[i] &&
             !(busy && (int'(g) == i)))
            set_mask[i] = 1'b1;
      end
   end
`else
   assign set_mask = req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         ptr      <= '0;
         g        <= '0;
         wcnt     <= '0;
         conv_gen <= 1'b0;
         conv_bin <= '0;
         bcd_q    <= '0;
         done     <= '0;
         busy     <= 1'b0;
`ifdef BCD_SCHED_CHANGE_DETECT_EN
         last_bin <= '0;
`endif
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               // A request arriving in the grant cycle survives the clear
               pending <= (pending & ~grant_oh) | set_mask;
               if (found) begin
                  g        <= grant_idx;
                  ptr      <= ptr_next;
                  conv_bin <= bin_in[6*int'(grant_idx) +: 6];
                  conv_gen <= 1'b1;
                  wcnt     <= '0;
                  busy     <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               pending  <= pending | set_mask;
               conv_gen <= 1'b0;
               if (wcnt == WW'(CONV_LAT)) begin
                  bcd_q[8*int'(g) +: 8] <= conv_bcd;
                  done[g]               <= 1'b1;
                  busy                  <= 1'b0;
                  state                 <= IDLE;
`ifdef BCD_SCHED_CHANGE_DETECT_EN
                  last_bin[6*int'(g) +: 6] <= conv_bin;
`endif
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - directed bench for bcd_conv_sched with a 13-cycle converter model
// Change-detect expectations follow BCD_SCHED_CHANGE_DETECT_EN.

module tb_bcd_conv_sched;
   localparam int NREQ     = 3;
   localparam int CONV_LAT = 13;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [6*NREQ-1:0] bin_in;
   logic              conv_gen;
   logic [5:0]        conv_bin;
   logic [7:0]        conv_bcd;
   logic [8*NREQ-1:0] bcd_q;
   logic [NREQ-1:0]   done;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bcd_conv_sched #(.NREQ(NREQ), .CONV_LAT(CONV_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
      .conv_gen(conv_gen), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
      .bcd_q(bcd_q), .done(done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] to_bcd(input logic [5:0] b);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(b / 10);
      o = 4'(b % 10);
      return {t, o};
   endfunction

   // Converter: result is garbage until CONV_LAT cycles after sampling gen
   logic [5:0] model_bin = '0;
   logic [7:0] model_bcd = 8'h00;
   int         model_cnt = 0;
   always @(posedge clk) begin
      if (conv_gen) begin
         model_bin <= conv_bin;
         model_cnt <= CONV_LAT - 1;
         model_bcd <= 8'hEE;
      end else if (model_cnt > 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) model_bcd <= to_bcd(model_bin);
      end
   end
   assign conv_bcd = model_bcd;

   logic [NREQ-1:0]   done_q[$];
   int                done_cyc[$];
   logic [8*NREQ-1:0] done_bcd[$];
   logic [5:0]        gen_q[$];
   int                gen_cyc[$];

   always @(negedge clk) begin
      if (conv_gen) begin
         gen_q.push_back(conv_bin);
         gen_cyc.push_back(cyc);
      end
      if (done != '0) begin
         done_q.push_back(done);
         done_cyc.push_back(cyc);
         done_bcd.push_back(bcd_q);
      end
   end

   task automatic clear_logs();
      done_q.delete(); done_cyc.delete(); done_bcd.delete();
      gen_q.delete(); gen_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      req    = '0;
      bin_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; bin_in = '0;
      @(posedge clk); #1;
      n_checks++; if (conv_gen !== 1'b0) begin n_fail++; $display("FAIL reset_gen: got %0h want 0", conv_gen); end
      n_checks++; if (conv_bin !== 6'd0) begin n_fail++; $display("FAIL reset_bin: got %0h want 0", conv_bin); end
      n_checks++; if (bcd_q !== '0) begin n_fail++; $display("FAIL reset_bcd: got %0h want 0", bcd_q); end
      n_checks++; if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
   endtask

   task automatic test_single();
      int c;
      do_reset();
      bin_in[11:6] = 6'd42; req = 3'b010; c = cyc;
      @(posedge clk); #1 req = '0;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1 || conv_gen !== 1'b1) begin n_fail++; $display("FAIL single_grant: busy %0h gen %0h want 1 1", busy, conv_gen); end
      repeat (22) @(posedge clk); #1;
      n_checks++; if (gen_q.size() != 1) begin n_fail++; $display("FAIL single_gen_count: got %0d want 1", gen_q.size()); end
      n_checks++; if (gen_q.size() < 1 || gen_q[0] !== 6'd42 || gen_cyc[0] != c + 2) begin n_fail++; $display("FAIL single_gen: got %0d entries want bin 42 at cycle %0d", gen_q.size(), c + 2); end
      n_checks++; if (done_q.size() != 1 || done_q[0] !== 3'b010) begin n_fail++; $display("FAIL single_done: got %0d pulses want one on bit 1", done_q.size()); end
      n_checks++; if (done_cyc.size() < 1 || done_cyc[0] != c + 16) begin n_fail++; $display("FAIL single_latency: got %0d pulses, want cycle %0d", done_cyc.size(), c + 16); end
      n_checks++; if (bcd_q[15:8] !== 8'h42) begin n_fail++; $display("FAIL single_bcd: got %0h want 42", bcd_q[15:8]); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %0h want 0", busy); end
   endtask

   task automatic test_round_robin();
      int c;
      logic [7:0] exp_bcd[3];
      logic [8*NREQ-1:0] tmp;
      exp_bcd[0] = 8'h05; exp_bcd[1] = 8'h17; exp_bcd[2] = 8'h63;
      do_reset();
      bin_in = {6'd63, 6'd17, 6'd5}; req = 3'b111; c = cyc;
      @(posedge clk); #1 req = '0;
      repeat (52) @(posedge clk); #1;
      n_checks++; if (done_q.size() != 3) begin n_fail++; $display("FAIL rr_count: got %0d want 3", done_q.size()); end
      for (int i = 0; i < 3 && i < done_q.size(); i++) begin
         tmp = done_bcd[i];
         n_checks++; if (done_q[i] !== 3'(1 << i)) begin n_fail++; $display("FAIL rr_order%0d: got %0b want %0b", i, done_q[i], 3'(1 << i)); end
         n_checks++; if (done_cyc[i] != c + 16 + 15 * i) begin n_fail++; $display("FAIL rr_cycle%0d: got %0d want %0d", i, done_cyc[i], c + 16 + 15 * i); end
         n_checks++; if (tmp[8*i +: 8] !== exp_bcd[i]) begin n_fail++; $display("FAIL rr_bcd%0d: got %0h want %0h", i, tmp[8*i +: 8], exp_bcd[i]); end
      end
   endtask

   task automatic test_operand_change();
      int c;
      int bad;
      int exp_n;
`ifdef BCD_SCHED_CHANGE_DETECT_EN
      exp_n = 2;
`else
      exp_n = 1;
`endif
      bad = 0;
      do_reset();
      bin_in[5:0] = 6'd9; req = 3'b001; c = cyc;
      @(posedge clk); #1 req = '0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (cyc == c + 5) bin_in[5:0] = 6'd30;
         if (cyc >= c + 2 && cyc <= c + 16 && conv_bin !== 6'd9) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL opchg_hold: %0d cycles with conv_bin not 9, want 0", bad); end
      n_checks++; if (done_q.size() != exp_n) begin n_fail++; $display("FAIL opchg_count: got %0d want %0d", done_q.size(), exp_n); end
      n_checks++; if (done_cyc.size() < 1 || done_cyc[0] != c + 16 || done_q[0] !== 3'b001) begin n_fail++; $display("FAIL opchg_done: got %0d pulses want bit 0 at cycle %0d", done_q.size(), c + 16); end
      n_checks++; if (done_bcd.size() < 1 || done_bcd[0][7:0] !== 8'h09) begin n_fail++; $display("FAIL opchg_bcd: got %0d pulses want result 09", done_bcd.size()); end
`ifdef BCD_SCHED_CHANGE_DETECT_EN
      n_checks++; if (bcd_q[7:0] !== 8'h30) begin n_fail++; $display("FAIL opchg_reconv: got %0h want 30", bcd_q[7:0]); end
`endif
   endtask

   task automatic test_rerequest();
      int c;
      do_reset();
      bin_in[17:12] = 6'd7; req = 3'b100; c = cyc;
      @(posedge clk); #1;
      @(posedge clk); #1 req = '0;
      repeat (38) @(posedge clk); #1;
      n_checks++; if (gen_q.size() != 2) begin n_fail++; $display("FAIL rereq_gen: got %0d want 2", gen_q.size()); end
      n_checks++; if (done_q.size() != 2) begin n_fail++; $display("FAIL rereq_count: got %0d want 2", done_q.size()); end
      for (int i = 0; i < 2 && i < done_q.size(); i++) begin
         n_checks++; if (done_q[i] !== 3'b100 || done_cyc[i] != c + 16 + 15 * i) begin n_fail++; $display("FAIL rereq_done%0d: got %0b at %0d want 100 at %0d", i, done_q[i], done_cyc[i], c + 16 + 15 * i); end
      end
      n_checks++; if (bcd_q[23:16] !== 8'h07) begin n_fail++; $display("FAIL rereq_bcd: got %0h want 07", bcd_q[23:16]); end
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset();
      bin_in[11:6] = 6'd55; req = 3'b010;
      @(posedge clk); #1 req = '0;
      repeat (18) @(posedge clk); #1;
      n_checks++; if (bcd_q[15:8] !== 8'h55) begin n_fail++; $display("FAIL rstmid_pre_bcd: got %0h want 55", bcd_q[15:8]); end
      bin_in = '0; bin_in[5:0] = 6'd3; req = 3'b001; c = cyc;
      @(posedge clk); #1 req = '0;
      while (cyc < c + 6) begin @(posedge clk); #1; end
      n_checks++; if (busy !== 1'b1 || conv_bin !== 6'd3) begin n_fail++; $display("FAIL rstmid_pre_busy: busy %0h bin %0d want 1 3", busy, conv_bin); end
      clear_logs();
      rst_n = 1'b0; bin_in = '0;
      #1;
      n_checks++; if (busy !== 1'b0 || conv_gen !== 1'b0 || done !== '0) begin n_fail++; $display("FAIL rstmid_ctrl: busy %0h gen %0h done %0h want 0", busy, conv_gen, done); end
      n_checks++; if (conv_bin !== 6'd0) begin n_fail++; $display("FAIL rstmid_bin: got %0d want 0", conv_bin); end
      n_checks++; if (bcd_q !== '0) begin n_fail++; $display("FAIL rstmid_bcd: got %0h want 0", bcd_q); end
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      n_checks++; if (done_q.size() != 0 || gen_q.size() != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d done %0d gen want 0 0", done_q.size(), gen_q.size()); end
      bin_in[5:0] = 6'd21; req = 3'b001; c = cyc;
      @(posedge clk); #1 req = '0;
      repeat (20) @(posedge clk); #1;
      n_checks++; if (done_q.size() != 1 || done_cyc[0] != c + 16) begin n_fail++; $display("FAIL rstmid_fresh_done: got %0d pulses want 1 at %0d", done_q.size(), c + 16); end
      n_checks++; if (bcd_q[7:0] !== 8'h21) begin n_fail++; $display("FAIL rstmid_fresh_bcd: got %0h want 21", bcd_q[7:0]); end
   endtask

   task automatic test_change_detect();
      int c;
      do_reset();
      bin_in[17:12] = 6'd12; c = cyc;
      repeat (45) @(posedge clk); #1;
`ifdef BCD_SCHED_CHANGE_DETECT_EN
      n_checks++; if (done_q.size() != 1) begin n_fail++; $display("FAIL chg_count: got %0d want 1", done_q.size()); end
      n_checks++; if (done_q.size() < 1 || done_q[0] !== 3'b100 || done_cyc[0] != c + 16) begin n_fail++; $display("FAIL chg_done: got %0d pulses want bit 2 at %0d", done_q.size(), c + 16); end
      n_checks++; if (bcd_q[23:16] !== 8'h12) begin n_fail++; $display("FAIL chg_bcd: got %0h want 12", bcd_q[23:16]); end
`else
      n_checks++; if (done_q.size() != 0 || gen_q.size() != 0) begin n_fail++; $display("FAIL chg_none: got %0d done %0d gen want 0 0", done_q.size(), gen_q.size()); end
      n_checks++; if (bcd_q !== '0) begin n_fail++; $display("FAIL chg_bcd: got %0h want 0", bcd_q); end
`endif
   endtask

   initial begin
      rst_n = 1'b0; req = '0; bin_in = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_operand_change();
      test_rerequest();
      test_reset_mid();
      test_change_detect();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
